program_sequencer: RTL and testbench
====================================

Name: program_sequencer

Overview:
- Parametrised next-generation program counter for the instruction fetch path.
- Supports increment, absolute jump, PC-relative branch, subroutine call and return.
- Keeps an internal return-address stack (LIFO) and reports its depth, full/empty and a sticky fault flag.
- Drives the instruction-memory address; the existing controller drives enable and op.

Parameters:
- ADDR_W, 16, width of PC, target and offset in bits.
- STACK_DEPTH, 8, number of return-address entries (>=2).
- RESET_ADDR, 0, value loaded into index on reset.

Ports:
- clock  input  1  system clock, rising-edge active.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  when 1, op is executed this cycle; when 0, all state holds.
- op  input  3  0=INC, 1=JUMP, 2=BRANCH, 3=CALL, 4=RET, 5..7=NOP (hold).
- target  input  ADDR_W  absolute address for JUMP and CALL.
- offset  input  ADDR_W  two's-complement displacement for BRANCH.
- clear_fault  input  1  synchronous clear of stack_fault.
- index  output  ADDR_W  current PC (registered).
- ret_depth  output  $clog2(STACK_DEPTH+1)  number of valid stack entries.
- stack_full  output  1  ret_depth == STACK_DEPTH (combinational from ret_depth).
- stack_empty  output  1  ret_depth == 0.
- stack_fault  output  1  sticky: overflow or underflow has occurred.

Behaviour:
- Reset (reset=0, asynchronous): index=RESET_ADDR, ret_depth=0, stack_fault=0, stack contents don't-care.
- All updates occur on the rising clock edge; the new index is visible 1 cycle after op is sampled.
- enable=0: index, stack and ret_depth hold. clear_fault still acts.
- INC: index <= index+1, modulo 2^ADDR_W (all-ones wraps to 0).
- JUMP: index <= target.
- BRANCH: index <= index+offset, modulo 2^ADDR_W. Offset is signed; carry/borrow is discarded.
- CALL when not full:
  - push (index+1 mod 2^ADDR_W) into the stack.
  - ret_depth += 1.
  - index <= target.
- CALL when full: no push, index holds, ret_depth holds, stack_fault <= 1.
- RET when not empty: index <= top entry, pop, ret_depth -= 1.
- RET when empty: index holds, stack_fault <= 1.
- NOP codes: hold everything; no fault.
- clear_fault=1 together with a faulting op in the same cycle: the fault wins, so stack_fault=1.
- Only one op per cycle, so push and pop are never simultaneous.
- Reset asserted mid-sequence: the stack is discarded immediately and ret_depth reads 0 during reset.

Decomposition:
- Shared package program_sequencer_pkg holds:
  - the op encodings OP_INC, OP_JUMP, OP_BRANCH, OP_CALL, OP_RET;
  - the op width constant OP_W=3.
- Sub-module return_stack: parametrised LIFO (ADDR_W, STACK_DEPTH).
  - Ports: clock, reset, push, pop, push_data, top_data, depth, full, empty.
  - It ignores push when full and pop when empty.
  - The parent raises the fault.

Test Plan:
- Reset, then INC x3 with RESET_ADDR=0 -> index 0,1,2,3. Assert reset mid-count -> index=0 immediately, without waiting for a clock.
- index=16'hFFFF, INC -> 16'h0000. index=16'h0010, BRANCH offset=16'hFFF8 (-8) -> 16'h0008.
- index=16'h0020, CALL target=16'h0100 -> index=16'h0100, ret_depth=1. Then INC, then RET -> index=16'h0021, ret_depth=0, stack_empty=1.
- STACK_DEPTH=8: nine CALLs -> ret_depth stays 8, stack_full=1, stack_fault=1, index unchanged on the 9th. Eight RETs then return the addresses in LIFO order.
- RET on empty stack -> index holds, stack_fault=1. Then clear_fault=1 with op=NOP -> stack_fault=0. Then clear_fault=1 with RET on empty -> stack_fault stays 1.
- enable=0 with op=CALL target=16'h0200 -> index, ret_depth and stack_fault all unchanged.

Source files
------------

// File: rtl/program_sequencer_pkg.sv
// Op encodings shared by the program sequencer and its bench.
package program_sequencer_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_INC    = 3'd0;
  localparam logic [OP_W-1:0] OP_JUMP   = 3'd1;
  localparam logic [OP_W-1:0] OP_BRANCH = 3'd2;
  localparam logic [OP_W-1:0] OP_CALL   = 3'd3;
  localparam logic [OP_W-1:0] OP_RET    = 3'd4;

endpackage

// File: rtl/program_sequencer_return_stack.sv
// Return-address LIFO: push/pop take effect on the next edge; push when full and pop when empty are dropped.
// top_data is the current top entry, valid whenever empty is low.
module return_stack #(
  parameter int ADDR_W      = 16,
  parameter int STACK_DEPTH = 8,
  localparam int DEPTH_W    = $clog2(STACK_DEPTH + 1)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               push,
  input  logic               pop,
  input  logic [ADDR_W-1:0]  push_data,
  output logic [ADDR_W-1:0]  top_data,
  output logic [DEPTH_W-1:0] depth,
  output logic               full,
  output logic               empty
);

  localparam int IDX_W = $clog2(STACK_DEPTH);

  logic [ADDR_W-1:0]  r_mem [STACK_DEPTH];
  logic [DEPTH_W-1:0] r_depth;

  logic             w_full;
  logic             w_empty;
  logic             w_do_push;
  logic             w_do_pop;
  logic [IDX_W-1:0] w_wr_idx;
  logic [IDX_W-1:0] w_rd_idx;

  assign w_full    = (r_depth == DEPTH_W'(STACK_DEPTH));
  assign w_empty   = (r_depth == '0);
  assign w_do_push = push && !w_full;
  assign w_do_pop  = pop && !w_empty;
  assign w_wr_idx  = IDX_W'(r_depth);
  assign w_rd_idx  = IDX_W'(r_depth - DEPTH_W'(1));

  // Depth alone tracks validity, so entries need no reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_depth <= '0;
    end else if (w_do_push) begin
      r_depth <= r_depth + DEPTH_W'(1);
    end else if (w_do_pop) begin
      r_depth <= r_depth - DEPTH_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (w_do_push) begin
      r_mem[w_wr_idx] <= push_data;
    end
  end

  assign top_data = r_mem[w_rd_idx];
  assign depth    = r_depth;
  assign full     = w_full;
  assign empty    = w_empty;

endmodule

// File: rtl/program_sequencer.sv
// Program counter with INC/JUMP/BRANCH/CALL/RET and a return stack; new index one cycle after op.
// No backpressure: enable=0 freezes state; stack over/underflow sets a sticky fault instead.
module program_sequencer
  import program_sequencer_pkg::*;
#(
  parameter int                 ADDR_W      = 16,
  parameter int                 STACK_DEPTH = 8,
  parameter logic [ADDR_W-1:0]  RESET_ADDR  = '0
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               enable,
  input  logic [OP_W-1:0]                    op,
  input  logic [ADDR_W-1:0]                  target,
  input  logic [ADDR_W-1:0]                  offset,
  input  logic                               clear_fault,
  output logic [ADDR_W-1:0]                  index,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   ret_depth,
  output logic                               stack_full,
  output logic                               stack_empty,
  output logic                               stack_fault
);

  logic [ADDR_W-1:0] r_index;
  logic              r_fault;

  logic [ADDR_W-1:0] w_index_nxt;
  logic [ADDR_W-1:0] w_top;
  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic              w_fault_evt;

  assign w_push      = enable && (op == OP_CALL) && !w_full;
  assign w_pop       = enable && (op == OP_RET) && !w_empty;
  assign w_fault_evt = enable && (((op == OP_CALL) && w_full) ||
                                  ((op == OP_RET) && w_empty));

  return_stack #(
    .ADDR_W      (ADDR_W),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_stack (
    .clock     (clock),
    .reset     (reset),
    .push      (w_push),
    .pop       (w_pop),
    .push_data (r_index + ADDR_W'(1)),
    .top_data  (w_top),
    .depth     (ret_depth),
    .full      (w_full),
    .empty     (w_empty)
  );

  // Faulting CALL/RET leave the index where it was.
  always_comb begin
    w_index_nxt = r_index;
    if (enable) begin
      case (op)
        OP_INC:    w_index_nxt = r_index + ADDR_W'(1);
        OP_JUMP:   w_index_nxt = target;
        OP_BRANCH: w_index_nxt = r_index + offset;
        OP_CALL:   if (!w_full)  w_index_nxt = target;
        OP_RET:    if (!w_empty) w_index_nxt = w_top;
        default:   w_index_nxt = r_index;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_index <= RESET_ADDR;
    end else begin
      r_index <= w_index_nxt;
    end
  end

  // A fault raised in the same cycle as clear_fault takes priority.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_fault <= 1'b0;
    end else if (w_fault_evt) begin
      r_fault <= 1'b1;
    end else if (clear_fault) begin
      r_fault <= 1'b0;
    end
  end

  assign index       = r_index;
  assign stack_full  = w_full;
  assign stack_empty = w_empty;
  assign stack_fault = r_fault;

endmodule

// File: tb/tb_program_sequencer.sv
// Directed bench for program_sequencer: reference model compared every cycle plus literal spot checks.
module tb_program_sequencer;
  import program_sequencer_pkg::*;

  localparam int          AW    = 16;
  localparam int          DEPTH = 8;
  localparam logic [15:0] RADDR = 16'h0000;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          enable = 1'b0;
  logic [2:0]    op = 3'd0;
  logic [AW-1:0] target = '0;
  logic [AW-1:0] offset = '0;
  logic          clear_fault = 1'b0;
  logic [AW-1:0] index;
  logic [3:0]    ret_depth;
  logic          stack_full;
  logic          stack_empty;
  logic          stack_fault;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  program_sequencer #(
    .ADDR_W      (AW),
    .STACK_DEPTH (DEPTH),
    .RESET_ADDR  (RADDR)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .op          (op),
    .target      (target),
    .offset      (offset),
    .clear_fault (clear_fault),
    .index       (index),
    .ret_depth   (ret_depth),
    .stack_full  (stack_full),
    .stack_empty (stack_empty),
    .stack_fault (stack_fault)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: PC plus an array-backed return stack.
  logic [AW-1:0] m_index;
  logic [AW-1:0] m_stk [DEPTH];
  int            m_dep;
  logic          m_fault;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_index <= RADDR;
      m_dep   <= 0;
      m_fault <= 1'b0;
    end else begin
      if (clear_fault) m_fault <= 1'b0;
      if (enable) begin
        if (op == OP_INC) m_index <= m_index + 16'd1;
        else if (op == OP_JUMP) m_index <= target;
        else if (op == OP_BRANCH) m_index <= m_index + offset;
        else if (op == OP_CALL) begin
          if (m_dep == DEPTH) m_fault <= 1'b1;
          else begin
            m_stk[m_dep] <= m_index + 16'd1;
            m_dep        <= m_dep + 1;
            m_index      <= target;
          end
        end else if (op == OP_RET) begin
          if (m_dep == 0) m_fault <= 1'b1;
          else begin
            m_index <= m_stk[m_dep-1];
            m_dep   <= m_dep - 1;
          end
        end
      end
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      check("cmp_index", 32'(index), 32'(m_index));
      check("cmp_depth", 32'(ret_depth), 32'(m_dep));
      check("cmp_full", 32'(stack_full), 32'(m_dep == DEPTH));
      check("cmp_empty", 32'(stack_empty), 32'(m_dep == 0));
      check("cmp_fault", 32'(stack_fault), 32'(m_fault));
    end
  end

  task automatic step(input logic en, input logic [2:0] o, input logic [15:0] tg,
                      input logic [15:0] off, input logic clr);
    enable = en; op = o; target = tg; offset = off; clear_fault = clr;
    @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  logic [15:0] ret_exp [8];

  initial begin
    ret_exp[0] = 16'h2601; ret_exp[1] = 16'h2501; ret_exp[2] = 16'h2401; ret_exp[3] = 16'h2301;
    ret_exp[4] = 16'h2201; ret_exp[5] = 16'h2101; ret_exp[6] = 16'h2001; ret_exp[7] = 16'h1001;

    repeat (2) @(posedge clock);
    #1;
    chk_en = 1'b1;
    check("rst_index", 32'(index), 32'h0);
    check("rst_depth", 32'(ret_depth), 32'h0);
    check("rst_empty", 32'(stack_empty), 32'h1);
    check("rst_fault", 32'(stack_fault), 32'h0);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;

    for (int i = 1; i <= 3; i++) begin
      step(1, OP_INC, 16'h0, 16'h0, 0);
      check("inc_count", 32'(index), 32'(i));
    end

    #2 reset = 1'b0;
    #1;
    check("async_rst_index", 32'(index), 32'h0);
    check("async_rst_depth", 32'(ret_depth), 32'h0);
    enable = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;

    step(1, OP_JUMP, 16'hFFFF, 16'h0, 0);
    step(1, OP_INC, 16'h0, 16'h0, 0);
    check("inc_wrap", 32'(index), 32'h0000);
    step(1, OP_JUMP, 16'h0010, 16'h0, 0);
    step(1, OP_BRANCH, 16'h0, 16'hFFF8, 0);
    check("branch_neg", 32'(index), 32'h0008);
    step(1, OP_BRANCH, 16'h0, 16'h0005, 0);
    check("branch_pos", 32'(index), 32'h000D);

    step(1, OP_JUMP, 16'h0020, 16'h0, 0);
    step(1, OP_CALL, 16'h0100, 16'h0, 0);
    check("call_index", 32'(index), 32'h0100);
    check("call_depth", 32'(ret_depth), 32'h1);
    step(1, OP_INC, 16'h0, 16'h0, 0);
    step(1, OP_RET, 16'h0, 16'h0, 0);
    check("ret_index", 32'(index), 32'h0021);
    check("ret_depth", 32'(ret_depth), 32'h0);
    check("ret_empty", 32'(stack_empty), 32'h1);

    step(1, OP_JUMP, 16'h1000, 16'h0, 0);
    for (int k = 0; k < 9; k++) begin
      step(1, OP_CALL, 16'h2000 + 16'(k) * 16'h0100, 16'h0, 0);
    end
    check("ovf_index", 32'(index), 32'h2700);
    check("ovf_depth", 32'(ret_depth), 32'h8);
    check("ovf_full", 32'(stack_full), 32'h1);
    check("ovf_fault", 32'(stack_fault), 32'h1);
    for (int j = 0; j < 8; j++) begin
      step(1, OP_RET, 16'h0, 16'h0, 0);
      check("lifo_ret", 32'(index), 32'(ret_exp[j]));
    end
    check("lifo_empty", 32'(stack_empty), 32'h1);

    step(1, 3'd5, 16'h0, 16'h0, 1);
    check("clr_nop_fault", 32'(stack_fault), 32'h0);
    step(1, OP_RET, 16'h0, 16'h0, 0);
    check("unf_index", 32'(index), 32'h1001);
    check("unf_fault", 32'(stack_fault), 32'h1);
    step(1, 3'd7, 16'h0, 16'h0, 1);
    check("clr_nop7_fault", 32'(stack_fault), 32'h0);
    check("nop_index", 32'(index), 32'h1001);
    step(1, OP_RET, 16'h0, 16'h0, 1);
    check("clr_vs_fault", 32'(stack_fault), 32'h1);

    step(1, OP_CALL, 16'h3000, 16'h0, 0);
    step(0, OP_CALL, 16'h0200, 16'h0, 0);
    check("dis_index", 32'(index), 32'h3000);
    check("dis_depth", 32'(ret_depth), 32'h1);
    check("dis_fault", 32'(stack_fault), 32'h1);
    step(0, OP_RET, 16'h0, 16'h0, 1);
    check("dis_clr_fault", 32'(stack_fault), 32'h0);
    check("dis_ret_index", 32'(index), 32'h3000);
    step(1, OP_RET, 16'h0, 16'h0, 0);
    check("final_ret", 32'(index), 32'h1002);

    @(negedge clock);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
